// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, LOST} clk_mon_state_t;

  localparam int CLK_MON_SYNC_MIN = 2;

endpackage

// File: rtl/sv_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared by reset_n.
module sv_bit_sync
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  localparam int DEPTH = (SYNC_STAGES < CLK_MON_SYNC_MIN) ? CLK_MON_SYNC_MIN : SYNC_STAGES;

  logic [DEPTH-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[DEPTH-2:0], i_async};
  end

  assign o_sync = r_sync[DEPTH-1];

endmodule

// File: rtl/sv_clk_monitor.sv
// Divided-clock monitor: synchronises div_clk, emits rise/fall ticks, measures the
// rise-to-rise period in clk_in cycles and tracks lock/loss against expected_period.
// Optional feature macro CLK_MON_DUTY_EN adds the high_time output (rise-to-fall width).
module sv_clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             div_clk,
  input  logic [CNT_W-1:0] expected_period,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
`ifdef CLK_MON_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // One extra bit keeps the difference free of underflow.
  function automatic logic within_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d <= $signed((CNT_W+1)'(TOL));
  endfunction

  logic             w_sync;
  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic             w_match;
  logic             r_prev;
  logic             r_rise_tick;
  logic             r_fall_tick;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_pv;
  logic             r_seen;
  clk_mon_state_t   r_state;
  logic [MC_W-1:0]  r_match_cnt;
  logic             r_locked;
  logic             r_lost;

  sv_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .i_async (div_clk),
    .o_sync  (w_sync)
  );

  assign w_rise    = w_sync & ~r_prev;
  assign w_fall    = ~w_sync & r_prev;
  // A rise arriving in the same cycle suppresses the timeout.
  assign w_timeout = !w_rise && (int'(r_cnt) == TIMEOUT - 1);
  assign w_match   = r_pv && (expected_period != '0) && within_tol(r_period, expected_period);

  // Edge detect on the synchronised clock; ticks are registered.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_prev      <= 1'b0;
      r_rise_tick <= 1'b0;
      r_fall_tick <= 1'b0;
    end else begin
      r_prev      <= w_sync;
      r_rise_tick <= w_rise;
      r_fall_tick <= w_fall;
    end
  end

  // Period counter: captured on each rise with a valid start point, re-armed on timeout.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_seen   <= 1'b0;
    end else if (w_rise) begin
      r_cnt  <= '0;
      r_seen <= 1'b1;
      r_pv   <= r_seen;
      if (r_seen) r_period <= sat_inc(r_cnt);
    end else if (w_timeout) begin
      r_cnt  <= '0;
      r_seen <= 1'b0;
      r_pv   <= 1'b0;
    end else begin
      r_cnt  <= sat_inc(r_cnt);
      r_pv   <= 1'b0;
    end
  end

  // Lock FSM acting on the registered period, with registered locked/lost flags.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_rise_tick) begin
            r_state     <= MEASURE;
            r_match_cnt <= '0;
          end
        end
        MEASURE: begin
          if (w_timeout) begin
            r_state     <= IDLE;
            r_match_cnt <= '0;
          end else if (r_pv) begin
            if (w_match) begin
              r_match_cnt <= r_match_cnt + 1'b1;
              if (int'(r_match_cnt) + 1 >= LOCK_COUNT) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (w_timeout || (r_pv && !w_match)) begin
            r_state  <= LOST;
            r_locked <= 1'b0;
            r_lost   <= 1'b1;
          end
        end
        LOST: begin
          if (w_match) begin
            r_state     <= MEASURE;
            r_match_cnt <= MC_W'(1);
            r_lost      <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
          r_lost   <= 1'b0;
        end
      endcase
    end
  end

  assign rise_tick    = r_rise_tick;
  assign fall_tick    = r_fall_tick;
  assign period       = r_period;
  assign period_valid = r_pv;
  assign locked       = r_locked;
  assign lost         = r_lost;

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high_time;
  logic             r_harm;

  // High-phase width: counted from a rise, captured on the following fall.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt      <= '0;
      r_high_time <= '0;
      r_harm      <= 1'b0;
    end else begin
      if (w_rise) begin
        r_hcnt <= '0;
        r_harm <= 1'b1;
      end else begin
        r_hcnt <= sat_inc(r_hcnt);
      end
      if (w_fall && r_harm) r_high_time <= sat_inc(r_hcnt);
    end
  end

  assign high_time = r_high_time;
`endif

endmodule

// File: tb/tb_sv_clk_monitor.sv
// Self-checking bench for sv_clk_monitor: a 16-bit instance with default parameters,
// plus a CNT_W=4 instance for counter saturation. The narrow instance's TIMEOUT is set
// beyond its counter range so a 20-cycle period can still be measured.
module tb_sv_clk_monitor;

  localparam int TIMEOUT = 1024;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        div_clk = 1'b0;
  logic [15:0] expected_period = 16'd4;
  logic [3:0]  exp_s = 4'd4;

  logic        rise_tick, fall_tick, period_valid, locked, lost;
  logic [15:0] period;
  logic        s_rise, s_fall, s_pv, s_locked, s_lost;
  logic [3:0]  s_period;
`ifdef CLK_MON_DUTY_EN
  logic [15:0] high_time;
  logic [3:0]  s_high_time;
`endif

  sv_clk_monitor #(.SYNC_STAGES(2), .CNT_W(16), .LOCK_COUNT(4), .TOL(1), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .div_clk(div_clk), .expected_period(expected_period),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .period(period), .period_valid(period_valid),
    .locked(locked), .lost(lost)
`ifdef CLK_MON_DUTY_EN
    , .high_time(high_time)
`endif
  );

  sv_clk_monitor #(.SYNC_STAGES(2), .CNT_W(4), .LOCK_COUNT(4), .TOL(1), .TIMEOUT(32)) dut_s (
    .clk_in(clk_in), .reset_n(reset_n), .div_clk(div_clk), .expected_period(exp_s),
    .rise_tick(s_rise), .fall_tick(s_fall), .period(s_period), .period_valid(s_pv),
    .locked(s_locked), .lost(s_lost)
`ifdef CLK_MON_DUTY_EN
    , .high_time(s_high_time)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int q_exp[$];
  bit seen_model = 1'b0;
  bit track = 1'b0;
  int since_rise = 0;

  task automatic cyc();
    @(posedge clk_in);
    #1;
    since_rise++;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  // Drives div_clk; every rise after a valid start point queues the expected period.
  task automatic set_div(input logic v);
    if (v && !div_clk && track) begin
      if (seen_model) q_exp.push_back(since_rise);
      since_rise = 0;
      seen_model = 1'b1;
    end
    div_clk = v;
  endtask

  task automatic wave(input int hi, input int lo);
    set_div(1'b1);
    hold(hi);
    set_div(1'b0);
    hold(lo);
  endtask

  // Scoreboard: each period_valid pops the oldest expected period.
  always @(posedge clk_in) begin
    int e;
    #1;
    if (period_valid) begin
      n_tests++;
      if (q_exp.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_valid: period_valid=1 period=%0d, no period expected", period);
      end else begin
        e = q_exp.pop_front();
        if (e > 65535) e = 65535;
        if (period !== 16'(e)) begin
          n_fail++;
          $display("FAIL sb_period: got %0d, expected %0d", period, e);
        end
      end
    end
  end

  task automatic test_reset();
    track = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      div_clk = i[1];
      cyc();
      n_tests++;
      if ({rise_tick, fall_tick, period, period_valid, locked, lost} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rt=%b ft=%b p=%0d pv=%b lk=%b ls=%b, expected all 0",
                 rise_tick, fall_tick, period, period_valid, locked, lost);
      end
`ifdef CLK_MON_DUTY_EN
      n_tests++;
      if (high_time !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_high_time: got %0d, expected 0", high_time);
      end
`endif
    end
    div_clk = 1'b0;
    reset_n = 1'b1;
    hold(3);
    track = 1'b1;
    seen_model = 1'b0;
    since_rise = 0;
    set_div(1'b1);
    hold(2);
    n_tests++;
    if (rise_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_latency_early: rise_tick=%b after 2 edges, expected 0", rise_tick);
    end
    hold(1);
    n_tests++;
    if ({rise_tick, period_valid, locked, lost} !== 4'b1000) begin
      n_fail++;
      $display("FAIL first_rise: got rt=%b pv=%b lk=%b ls=%b, expected rt=1 pv=0 lk=0 ls=0",
               rise_tick, period_valid, locked, lost);
    end
  endtask

  task automatic test_steady();
    set_div(1'b0);
    hold(1);
    for (int i = 0; i < 3; i++) wave(2, 2);
    set_div(1'b1);
    hold(2);
    set_div(1'b0);
    hold(1);
    n_tests++;
    if ({period_valid, locked} !== 2'b10) begin
      n_fail++;
      $display("FAIL steady_before_lock: got pv=%b lk=%b, expected pv=1 lk=0", period_valid, locked);
    end
    hold(1);
    n_tests++;
    if ({locked, lost} !== 2'b10) begin
      n_fail++;
      $display("FAIL steady_lock: got lk=%b ls=%b, expected lk=1 ls=0", locked, lost);
    end
    set_div(1'b1);
    hold(1);
    n_tests++;
    if ({fall_tick, rise_tick} !== 2'b10) begin
      n_fail++;
      $display("FAIL fall_tick: got ft=%b rt=%b, expected ft=1 rt=0", fall_tick, rise_tick);
    end
    hold(1);
    n_tests++;
    if (fall_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_tick_width: got %b on the following cycle, expected 0", fall_tick);
    end
  endtask

  task automatic test_glitch();
    set_div(1'b0);
    hold(2);
    wave(3, 4);
    set_div(1'b1);
    hold(2);
    set_div(1'b0);
    hold(1);
    n_tests++;
    if ({locked, lost} !== 2'b10) begin
      n_fail++;
      $display("FAIL glitch_same_cycle: got lk=%b ls=%b, expected lk=1 ls=0", locked, lost);
    end
    hold(1);
    n_tests++;
    if ({locked, lost} !== 2'b01) begin
      n_fail++;
      $display("FAIL glitch_lost: got lk=%b ls=%b, expected lk=0 ls=1", locked, lost);
    end
    set_div(1'b1);
    hold(2);
    set_div(1'b0);
    hold(2);
    n_tests++;
    if ({locked, lost} !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch_remeasure: got lk=%b ls=%b, expected lk=0 ls=0", locked, lost);
    end
    wave(2, 2);
    wave(2, 2);
    set_div(1'b1);
    hold(2);
    set_div(1'b0);
    hold(1);
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_relock_early: got lk=%b, expected 0", locked);
    end
    hold(1);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_relock: got lk=%b, expected 1", locked);
    end
  endtask

  task automatic test_timeout();
    int k;
    k = 1;
    while (!lost && k < 3 * TIMEOUT) begin
      cyc();
      k++;
    end
    seen_model = 1'b0;
    n_tests++;
    if (k != TIMEOUT || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_lost: lost after %0d cycles (lk=%b), expected %0d cycles with lk=0",
               k, locked, TIMEOUT);
    end
    set_div(1'b1);
    hold(3);
    n_tests++;
    if ({rise_tick, period_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_first_rise: got rt=%b pv=%b, expected rt=1 pv=0", rise_tick, period_valid);
    end
    set_div(1'b0);
    hold(1);
    for (int i = 0; i < 3; i++) wave(2, 2);
    n_tests++;
    if ({locked, lost} !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_measure: got lk=%b ls=%b, expected lk=0 ls=0", locked, lost);
    end
    wave(2, 2);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_lock: got lk=%b, expected 1", locked);
    end
  endtask

  task automatic test_tolerance();
    wave(2, 3);
    set_div(1'b1);
    hold(2);
    set_div(1'b0);
    hold(2);
    n_tests++;
    if ({locked, lost} !== 2'b10) begin
      n_fail++;
      $display("FAIL tol_period5: got lk=%b ls=%b, expected lk=1 ls=0", locked, lost);
    end
    hold(2);
    set_div(1'b1);
    hold(2);
    set_div(1'b0);
    hold(2);
    n_tests++;
    if ({locked, lost} !== 2'b01) begin
      n_fail++;
      $display("FAIL tol_period6: got lk=%b ls=%b, expected lk=0 ls=1", locked, lost);
    end
  endtask

  task automatic test_expected_zero();
    expected_period = 16'd0;
    for (int i = 0; i < 6; i++) begin
      wave(2, 2);
      n_tests++;
      if ({locked, lost} !== 2'b01) begin
        n_fail++;
        $display("FAIL exp_zero_%0d: got lk=%b ls=%b, expected lk=0 ls=1", i, locked, lost);
      end
    end
    expected_period = 16'd4;
    for (int i = 0; i < 4; i++) wave(2, 2);
    n_tests++;
    if ({locked, lost} !== 2'b10) begin
      n_fail++;
      $display("FAIL exp_restored_lock: got lk=%b ls=%b, expected lk=1 ls=0", locked, lost);
    end
  endtask

  task automatic test_saturation();
    set_div(1'b1);
    hold(3);
    n_tests++;
    if ({s_pv, s_period} !== {1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL narrow_period4: got pv=%b period=%0d, expected pv=1 period=4", s_pv, s_period);
    end
    hold(7);
    set_div(1'b0);
    hold(10);
    set_div(1'b1);
    hold(3);
    n_tests++;
    if ({s_pv, s_period} !== {1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL narrow_saturate: got pv=%b period=%0d, expected pv=1 period=15", s_pv, s_period);
    end
    set_div(1'b0);
    hold(1);
  endtask

`ifdef CLK_MON_DUTY_EN
  task automatic test_duty();
    for (int i = 0; i < 3; i++) begin
      set_div(1'b1);
      hold(3);
      set_div(1'b0);
      hold(3);
      n_tests++;
      if ({fall_tick, high_time} !== {1'b1, 16'd3}) begin
        n_fail++;
        $display("FAIL duty_high_time_%0d: got ft=%b high_time=%0d, expected ft=1 high_time=3",
                 i, fall_tick, high_time);
      end
      hold(2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_steady();
    test_glitch();
    test_timeout();
    test_tolerance();
    test_expected_zero();
    test_saturation();
`ifdef CLK_MON_DUTY_EN
    test_duty();
`endif
    hold(6);
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected periods never reported, expected 0 left", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
